// File: rtl/hazard_forward_ctrl_pkg.sv
// Purpose: shared ISA field layout, opcode constants and forward-select encodings for the hazard block.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hazard_forward_ctrl_pkg;

  // Instruction field positions (opcode sits at the top of the word)
  localparam int OPC_W     = 5;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_LSB = 2;
  localparam int ALUOP_W   = 5;

  // 5-bit opcodes
  localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_LED  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_CAP  = 5'b01100;

  // Shift ALU ops are 0010x: they take a shamt instead of rt
  localparam logic [ALUOP_W-1:0] ALU_SHIFT_MASK = 5'b11110;
  localparam logic [ALUOP_W-1:0] ALU_SHIFT_OPS  = 5'b00100;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_XM  = 2'd1,
    FWD_MW  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic writes_rd;
    logic reads_rs;
    logic reads_rt;
    logic reads_rd;
    logic is_lw;
    logic is_sw;
  } insn_class_t;

  // Nearest producer wins: XM is younger than MW
  function automatic fwd_sel_e pick_fwd(input logic xm_hit, input logic mw_hit);
    if (xm_hit)      return FWD_XM;
    else if (mw_hit) return FWD_MW;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_insn_class_dec.sv
// Purpose: classify one instruction by which register fields it reads or writes.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure decode.
// Ports: insn (instruction word) -> writes_rd, reads_rs, reads_rt, reads_rd, is_lw, is_sw.
module insn_class_dec
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int INSN_W = 32
) (
  input  logic [INSN_W-1:0] insn,
  output logic              writes_rd,
  output logic              reads_rs,
  output logic              reads_rt,
  output logic              reads_rd,
  output logic              is_lw,
  output logic              is_sw
);

  logic [OPC_W-1:0]   opcode;
  logic [ALUOP_W-1:0] alu_op;
  logic               is_r;
  logic               unused_insn_bits;

  assign opcode = insn[INSN_W-1 -: OPC_W];
  assign alu_op = insn[ALUOP_LSB +: ALUOP_W];
  // Register and immediate fields are consumed by the caller, not here
  assign unused_insn_bits = ^insn;

  assign is_r  = (opcode == OP_R);
  assign is_lw = (opcode == OP_LW);
  assign is_sw = (opcode == OP_SW);

  assign writes_rd = is_r || (opcode == OP_ADDI) || is_lw || (opcode == OP_CAP);

  assign reads_rs = is_r || (opcode == OP_ADDI) || is_sw || is_lw ||
                    (opcode == OP_BNE) || (opcode == OP_BLT) || (opcode == OP_BEQ) ||
                    (opcode == OP_LED) || (opcode == OP_CAP);

  assign reads_rt = is_r && ((alu_op & ALU_SHIFT_MASK) != ALU_SHIFT_OPS);

  // Branches, jr, sw and led carry their B operand in the rd field
  assign reads_rd = (opcode == OP_BNE) || (opcode == OP_BLT) || (opcode == OP_BEQ) ||
                    (opcode == OP_JR)  || is_sw || (opcode == OP_LED);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Purpose: operand-forward selects, WM store bypass, load-use / multdiv stall and stall counter.
// Latency: selects and stall combinational (0 cycles); md_busy and stall_count update next edge.
// Backpressure: stall freezes PC/FD and bubbles DX; asserted until the hazard clears.
// Ports: clock, reset (async high); fd/dx/xm/mw_insn latch contents; md_start/md_ready multdiv
//        handshake; fwd_a_sel/fwd_b_sel (0 reg, 1 XM, 2 MW); wm_bypass; stall; md_busy; stall_count.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INSN_W-1:0] fd_insn,
  input  logic [INSN_W-1:0] dx_insn,
  input  logic [INSN_W-1:0] xm_insn,
  input  logic [INSN_W-1:0] mw_insn,
  input  logic              md_start,
  input  logic              md_ready,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              wm_bypass,
  output logic              stall,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int FD = 0;
  localparam int DX = 1;
  localparam int XM = 2;
  localparam int MW = 3;

  logic [INSN_W-1:0] stage_insn [4];
  insn_class_t       stage_cls  [4];

  assign stage_insn = '{fd_insn, dx_insn, xm_insn, mw_insn};

  for (genvar g = 0; g < 4; g++) begin : g_dec
    logic c_wr, c_rs, c_rt, c_rd, c_lw, c_sw;
    insn_class_dec #(.INSN_W(INSN_W)) u_dec (
      .insn      (stage_insn[g]),
      .writes_rd (c_wr),
      .reads_rs  (c_rs),
      .reads_rt  (c_rt),
      .reads_rd  (c_rd),
      .is_lw     (c_lw),
      .is_sw     (c_sw)
    );
    assign stage_cls[g] = '{writes_rd: c_wr, reads_rs: c_rs, reads_rt: c_rt,
                            reads_rd: c_rd, is_lw: c_lw, is_sw: c_sw};
  end

  insn_class_t fd_cls, dx_cls, xm_cls, mw_cls;
  assign fd_cls = stage_cls[FD];
  assign dx_cls = stage_cls[DX];
  assign xm_cls = stage_cls[XM];
  assign mw_cls = stage_cls[MW];

  logic [REG_AW-1:0] fd_rd, fd_rs, fd_rt;
  logic [REG_AW-1:0] dx_rd, dx_rs, dx_rt;
  logic [REG_AW-1:0] xm_rd, mw_rd;

  assign fd_rd = fd_insn[RD_LSB +: REG_AW];
  assign fd_rs = fd_insn[RS_LSB +: REG_AW];
  assign fd_rt = fd_insn[RT_LSB +: REG_AW];
  assign dx_rd = dx_insn[RD_LSB +: REG_AW];
  assign dx_rs = dx_insn[RS_LSB +: REG_AW];
  assign dx_rt = dx_insn[RT_LSB +: REG_AW];
  assign xm_rd = xm_insn[RD_LSB +: REG_AW];
  assign mw_rd = mw_insn[RD_LSB +: REG_AW];

  // True when an instruction with the given class/fields sources register r (r0 never counts)
  function automatic logic reads_reg(input insn_class_t c, input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] r);
    return (r != '0) && ((c.reads_rs && (rs == r)) || (c.reads_rt && (rt == r)) ||
                         (c.reads_rd && (rd == r)));
  endfunction

  // ---------------- operand forwarding ----------------
  // A operand is always rs; B is rd for the rd-readers, rt for R-type, else none (r0)
  logic [REG_AW-1:0] dx_a_reg, dx_b_reg;
  assign dx_a_reg = dx_cls.reads_rs ? dx_rs : '0;
  assign dx_b_reg = dx_cls.reads_rd ? dx_rd : (dx_cls.reads_rt ? dx_rt : '0);

  logic xm_hit_a, mw_hit_a, xm_hit_b, mw_hit_b;
  assign xm_hit_a = (dx_a_reg != '0) && xm_cls.writes_rd && (xm_rd == dx_a_reg);
  assign mw_hit_a = (dx_a_reg != '0) && mw_cls.writes_rd && (mw_rd == dx_a_reg);
  assign xm_hit_b = (dx_b_reg != '0) && xm_cls.writes_rd && (xm_rd == dx_b_reg);
  assign mw_hit_b = (dx_b_reg != '0) && mw_cls.writes_rd && (mw_rd == dx_b_reg);

  assign fwd_a_sel = pick_fwd(xm_hit_a, mw_hit_a);
  assign fwd_b_sel = pick_fwd(xm_hit_b, mw_hit_b);

  // Store in XM takes the value being written back by MW
  assign wm_bypass = xm_cls.is_sw && mw_cls.writes_rd && (xm_rd == mw_rd) && (xm_rd != '0);

  // ---------------- stalls ----------------
  logic [REG_AW-1:0] md_rd;
  logic              load_use;
  logic              md_hazard;

  assign load_use = dx_cls.is_lw && (dx_rd != '0) &&
                    reads_reg(fd_cls, fd_rs, fd_rt, fd_rd, dx_rd);

  // RAW and WAW against the outstanding multdiv result; released in the writeback cycle
  assign md_hazard = md_busy && (md_rd != '0) && !md_ready &&
                     (reads_reg(fd_cls, fd_rs, fd_rt, fd_rd, md_rd) ||
                      (fd_cls.writes_rd && (fd_rd == md_rd)));

  assign stall = load_use || md_hazard;

  // ---------------- multdiv scoreboard and stall counter ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy     <= 1'b0;
      md_rd       <= '0;
      stall_count <= '0;
    end else begin
      // A fresh issue overrides a coincident completion
      if (md_start) begin
        md_busy <= 1'b1;
        md_rd   <= dx_rd;
      end else if (md_ready) begin
        md_busy <= 1'b0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
